// File: rtl/mmcm0_rst_ctrl.sv
// MMCM reset sequencer: pulses the MMCM reset, waits for lock with timeout and retry,
// qualifies lock stability, then releases the downstream reset and watches for lock loss.
module mmcm0_rst_ctrl #(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned MAX_RETRY        = 7,
    parameter int unsigned CNT_W            = 16
) (
    input  logic       clk_in0,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       relock_req,
    output logic       mmcm_reset,
    output logic       sys_rst_n,
    output logic       fail,
    output logic [2:0] state,
    output logic [7:0] retry_cnt,
    output logic [7:0] lost_cnt
);

    typedef enum logic [2:0] {
        StRstPulse = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [7:0]       RetryMax    = 8'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       lost_q, lost_d;
    logic             sync1_q, locked_s_q;
    logic             mmcm_reset_q, mmcm_reset_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             fail_q, fail_d;
    logic             restart;
    logic             attempt_fail;

    // State register, synchroniser and registered outputs.
    always_ff @(posedge clk_in0 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StRstPulse;
            cnt_q        <= '0;
            retry_q      <= '0;
            lost_q       <= '0;
            sync1_q      <= 1'b0;
            locked_s_q   <= 1'b0;
            mmcm_reset_q <= 1'b1;
            sys_rst_n_q  <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            lost_q       <= lost_d;
            sync1_q      <= locked;
            locked_s_q   <= sync1_q;
            mmcm_reset_q <= mmcm_reset_d;
            sys_rst_n_q  <= sys_rst_n_d;
            fail_q       <= fail_d;
        end
    end

    // Next-state, retry/loss bookkeeping and phase counter.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        lost_d       = lost_q;
        restart      = 1'b0;
        attempt_fail = 1'b0;
        if (relock_req) begin
            state_d = StRstPulse;
            restart = 1'b1;
            if (state_q == StFail) retry_d = '0;
        end else begin
            case (state_q)
                StRstPulse: if (cnt_q == PulseLast) state_d = StWaitLock;
                StWaitLock: begin
                    if (locked_s_q)                 state_d = StStable;
                    else if (cnt_q == TimeoutLast)  attempt_fail = 1'b1;
                end
                StStable: begin
                    if (!locked_s_q) begin
                        attempt_fail = 1'b1;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                        retry_d = '0;
                    end
                end
                StRun: begin
                    if (!locked_s_q) begin
                        state_d = StRstPulse;
                        if (lost_q != 8'hff) lost_d = lost_q + 8'd1;
                    end
                end
                StFail:  state_d = StFail;
                default: state_d = StRstPulse;
            endcase
        end

        if (attempt_fail) begin
            if (retry_q == RetryMax) begin
                state_d = StFail;
            end else begin
                state_d = StRstPulse;
                retry_d = retry_q + 8'd1;
            end
        end

        // Counter restarts on any state entry, including a relock from RST_PULSE itself.
        if (restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (state_q inside {StRstPulse, StWaitLock, StStable}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_comb begin
        mmcm_reset_d = state_d inside {StRstPulse, StFail};
        sys_rst_n_d  = (state_d == StRun);
        fail_d       = (state_d == StFail);
    end

    assign mmcm_reset = mmcm_reset_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign fail       = fail_q;
    assign state      = state_q;
    assign retry_cnt  = retry_q;
    assign lost_cnt   = lost_q;

endmodule
